// File: rtl/tx_arb_pkg.sv
// Shared definitions for the transmitter arbiter: FSM state encoding.
package tx_arb_pkg;

  typedef logic [1:0] arbState_t;

  // Legacy-compatible fixed encoding; other blocks decode these values directly.
  localparam arbState_t IDLE = 2'd0;
  localparam arbState_t SEND = 2'd1;
  localparam arbState_t WAIT = 2'd2;
  localparam arbState_t ACK  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after `last`,
// searching upward with wrap-around. Returns a one-hot grant and its index.
module rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] index
);

  localparam logic [N-1:0] One = N'(1);

  int unsigned     cand;
  logic [IdxW-1:0] candIdx;
  logic            found;

  // Walk last+1 .. last+N (mod N) and keep the first requester found.
  always_comb begin
    cand    = 0;
    candIdx = '0;
    found   = 1'b0;
    index   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = 32'(last) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      candIdx = cand[IdxW-1:0];
      if (!found && req[candIdx]) begin
        found = 1'b1;
        index = candIdx;
      end
    end
    grant = found ? (One << index) : '0;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one byte transmitter (send pulse / done pulse) between
// N requesters. Latches the winner's byte, pulses send, waits for done or a watchdog
// expiry, then acknowledges the owner. All outputs are registered.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic           iClock,
  input  logic           iReset,
  input  logic [N-1:0]   iReq,
  input  logic [8*N-1:0] iData,
  input  logic           iTxDone,
  output logic           oTxSend,
  output logic [7:0]     oTxData,
  output logic [N-1:0]   oGrant,
  output logic [N-1:0]   oAck,
  output logic           oBusy,
  output logic           oTimeout
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

  arbState_t       stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic [IdxW-1:0] lastQ, lastD;
  logic [IdxW-1:0] ownerQ, ownerD;
  logic [N-1:0]    grantQ, grantD;
  logic [7:0]      dataQ, dataD;
  logic            sendQ, sendD;
  logic [N-1:0]    ackQ, ackD;
  logic            timeoutQ, timeoutD;
  logic            busyQ, busyD;

  logic [N-1:0]    pickGrant;
  logic [IdxW-1:0] pickIdx;
  logic [7:0]      pickData;

  rr_pick #(
    .N(N)
  ) uPick (
    .req  (iReq),
    .last (lastQ),
    .grant(pickGrant),
    .index(pickIdx)
  );

  // Select the winning requester's byte lane.
  always_comb begin
    pickData = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pickGrant[k]) begin
        pickData = iData[8*k +: 8];
      end
    end
  end

  // Next-state logic; pulse outputs default low so they last exactly one cycle.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    lastD    = lastQ;
    ownerD   = ownerQ;
    grantD   = grantQ;
    dataD    = dataQ;
    busyD    = busyQ;
    sendD    = 1'b0;
    ackD     = '0;
    timeoutD = 1'b0;
    case (stateQ)
      IDLE: begin
        if (|iReq) begin
          stateD = SEND;
          ownerD = pickIdx;
          grantD = pickGrant;
          dataD  = pickData;
          sendD  = 1'b1;
          busyD  = 1'b1;
        end
      end
      SEND: begin
        // A done arriving here is ignored: the transmitter was only just started.
        stateD = WAIT;
        cntD   = '0;
      end
      WAIT: begin
        if (iTxDone) begin
          // Done beats a simultaneous watchdog expiry.
          stateD = ACK;
          ackD   = grantQ;
        end else if (cntQ == CntLimit) begin
          stateD   = ACK;
          ackD     = grantQ;
          timeoutD = 1'b1;
        end else if (cntQ != CntMax) begin
          cntD = cntQ + CntW'(1);
        end
      end
      ACK: begin
        stateD = IDLE;
        lastD  = ownerQ;
        grantD = '0;
        busyD  = 1'b0;
      end
      default: begin
        stateD = IDLE;
        grantD = '0;
        busyD  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight without an ack.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      stateQ   <= IDLE;
      cntQ     <= '0;
      lastQ    <= IdxW'(N - 1);
      ownerQ   <= '0;
      grantQ   <= '0;
      dataQ    <= '0;
      sendQ    <= 1'b0;
      ackQ     <= '0;
      timeoutQ <= 1'b0;
      busyQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      lastQ    <= lastD;
      ownerQ   <= ownerD;
      grantQ   <= grantD;
      dataQ    <= dataD;
      sendQ    <= sendD;
      ackQ     <= ackD;
      timeoutQ <= timeoutD;
      busyQ    <= busyD;
    end
  end

  assign oTxSend  = sendQ;
  assign oTxData  = dataQ;
  assign oGrant   = grantQ;
  assign oAck     = ackQ;
  assign oBusy    = busyQ;
  assign oTimeout = timeoutQ;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter. Two instances share all inputs: dutA has a long
// watchdog for normal transfers, dutB a short one (TIMEOUT=8) for watchdog cases.
module tb_tx_arbiter;

  localparam int unsigned N        = 2;
  localparam int unsigned TimeoutA = 64;
  localparam int unsigned TimeoutB = 8;

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
    logic       tmo;
    int         lat;
  } expEntry_t;

  logic           clk = 1'b0;
  logic           rstN;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic           txDone;

  logic         aSend, aBusy, aTmo;
  logic [7:0]   aData;
  logic [N-1:0] aGrant, aAck;
  logic         bSend, bBusy, bTmo;
  logic [7:0]   bData;
  logic [N-1:0] bGrant, bAck;

  int total = 0;
  int bad   = 0;
  int sendA = 0;
  int ackA  = 0;
  int multiA = 0;
  expEntry_t expQ[$];

  always #5 clk = ~clk;

  tx_arbiter #(.N(N), .TIMEOUT(TimeoutA)) dutA (
    .iClock(clk), .iReset(rstN), .iReq(req), .iData(data), .iTxDone(txDone),
    .oTxSend(aSend), .oTxData(aData), .oGrant(aGrant), .oAck(aAck),
    .oBusy(aBusy), .oTimeout(aTmo)
  );

  tx_arbiter #(.N(N), .TIMEOUT(TimeoutB)) dutB (
    .iClock(clk), .iReset(rstN), .iReq(req), .iData(data), .iTxDone(txDone),
    .oTxSend(bSend), .oTxData(bData), .oGrant(bGrant), .oAck(bAck),
    .oBusy(bBusy), .oTimeout(bTmo)
  );

  // Event counters on dutA, sampled mid-cycle.
  always @(negedge clk) begin
    if (aSend === 1'b1) sendA <= sendA + 1;
    if (aAck !== '0) ackA <= ackA + 1;
    if ($countones(aGrant) > 1) multiA <= multiA + 1;
  end

  task automatic applyReset();
    req = '0;
    txDone = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Drives one transfer: waits for send, pulses done doneDelay cycles later (0 = never),
  // optionally drops the request and scrambles data, and returns what was observed.
  task automatic xfer(input bit useB, input int doneDelay, input int dropAt,
                      output logic [1:0] grantAtSend, output logic [7:0] dataAtSend,
                      output logic [1:0] ackSeen, output logic [7:0] dataAtAck,
                      output logic tmoSeen, output int lat);
    bit gotSend;
    bit gotAck;
    gotSend = 1'b0;
    gotAck = 1'b0;
    grantAtSend = '0;
    dataAtSend = '0;
    ackSeen = '0;
    dataAtAck = '0;
    tmoSeen = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !gotSend; i++) begin
      @(negedge clk);
      if ((useB ? bSend : aSend) === 1'b1) begin
        gotSend = 1'b1;
        grantAtSend = useB ? bGrant : aGrant;
        dataAtSend = useB ? bData : aData;
      end
    end
    if (!gotSend) return;
    for (int c = 1; c <= 80 && !gotAck; c++) begin
      @(posedge clk);
      #1;
      txDone = (c == doneDelay);
      if (c == dropAt) begin
        req = '0;
        data = '1;
      end
      @(negedge clk);
      if ((useB ? bAck : aAck) !== '0) begin
        gotAck = 1'b1;
        ackSeen = useB ? bAck : aAck;
        dataAtAck = useB ? bData : aData;
        tmoSeen = useB ? bTmo : aTmo;
        lat = c;
      end
    end
    txDone = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    req = '0;
    data = '0;
    txDone = 1'b0;
    #2 rstN = 1'b0;
    #10;
    total++; if (aSend !== 1'b0) begin bad++; $display("FAIL reset_send got=%0b want=0", aSend); end
    total++; if (aData !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", aData); end
    total++; if (aGrant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%0b want=0", aGrant); end
    total++; if (aAck !== 2'b00) begin bad++; $display("FAIL reset_ack got=%0b want=0", aAck); end
    total++; if (aBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", aBusy); end
    total++; if (aTmo !== 1'b0) begin bad++; $display("FAIL reset_tmo got=%0b want=0", aTmo); end
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (aBusy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b want=0", aBusy); end
  endtask

  task automatic test_single();
    expEntry_t e;
    logic [1:0] g, ak;
    logic [7:0] ds, da;
    logic tm;
    int lat;
    int sends0;
    applyReset();
    data = 16'h3CA5;
    req = 2'b01;
    expQ.push_back('{grant: 2'b01, data: 8'hA5, tmo: 1'b0, lat: 11});
    sends0 = sendA;
    xfer(1'b0, 10, 0, g, ds, ak, da, tm, lat);
    req = '0;
    e = expQ.pop_front();
    total++; if (g !== e.grant) begin bad++; $display("FAIL single_grant got=%0b want=%0b", g, e.grant); end
    total++; if (ds !== e.data) begin bad++; $display("FAIL single_data got=%0h want=%0h", ds, e.data); end
    total++; if (ak !== e.grant) begin bad++; $display("FAIL single_ack got=%0b want=%0b", ak, e.grant); end
    total++; if (tm !== e.tmo) begin bad++; $display("FAIL single_tmo got=%0b want=%0b", tm, e.tmo); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL single_lat got=%0d want=%0d", lat, e.lat); end
    @(negedge clk);
    total++; if (aAck !== 2'b00) begin bad++; $display("FAIL single_ack_pulse got=%0b want=0", aAck); end
    total++; if (aGrant !== 2'b00) begin bad++; $display("FAIL single_grant_clr got=%0b want=0", aGrant); end
    total++; if (aBusy !== 1'b0) begin bad++; $display("FAIL single_busy_clr got=%0b want=0", aBusy); end
    total++; if (sendA - sends0 !== 1) begin bad++; $display("FAIL single_sends got=%0d want=1", sendA - sends0); end
  endtask

  task automatic test_contention();
    expEntry_t e;
    logic [1:0] g, ak;
    logic [7:0] ds, da;
    logic tm;
    int lat;
    int sends0;
    int multi0;
    applyReset();
    data = 16'h2211;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expQ.push_back('{grant: 2'b01, data: 8'h11, tmo: 1'b0, lat: 4});
      else expQ.push_back('{grant: 2'b10, data: 8'h22, tmo: 1'b0, lat: 4});
    end
    sends0 = sendA;
    multi0 = multiA;
    for (int k = 0; k < 4; k++) begin
      xfer(1'b0, 3, 0, g, ds, ak, da, tm, lat);
      e = expQ.pop_front();
      total++; if (g !== e.grant) begin bad++; $display("FAIL rr_grant%0d got=%0b want=%0b", k, g, e.grant); end
      total++; if (ak !== e.grant) begin bad++; $display("FAIL rr_ack%0d got=%0b want=%0b", k, ak, e.grant); end
      total++; if (da !== e.data) begin bad++; $display("FAIL rr_data%0d got=%0h want=%0h", k, da, e.data); end
    end
    req = '0;
    repeat (2) @(negedge clk);
    total++; if (sendA - sends0 !== 4) begin bad++; $display("FAIL rr_sends got=%0d want=4", sendA - sends0); end
    total++; if (multiA !== multi0) begin bad++; $display("FAIL rr_onehot got=%0d want=%0d", multiA, multi0); end
  endtask

  task automatic test_timeout();
    expEntry_t e;
    logic [1:0] g, ak;
    logic [7:0] ds, da;
    logic tm;
    int lat;
    applyReset();
    data = 16'h5A00;
    req = 2'b10;
    expQ.push_back('{grant: 2'b10, data: 8'h5A, tmo: 1'b1, lat: TimeoutB + 1});
    xfer(1'b1, 0, 0, g, ds, ak, da, tm, lat);
    req = '0;
    e = expQ.pop_front();
    total++; if (ak !== e.grant) begin bad++; $display("FAIL tmo_ack got=%0b want=%0b", ak, e.grant); end
    total++; if (tm !== e.tmo) begin bad++; $display("FAIL tmo_flag got=%0b want=%0b", tm, e.tmo); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL tmo_lat got=%0d want=%0d", lat, e.lat); end
    total++; if (da !== e.data) begin bad++; $display("FAIL tmo_data got=%0h want=%0h", da, e.data); end
    @(negedge clk);
    total++; if (bTmo !== 1'b0) begin bad++; $display("FAIL tmo_pulse got=%0b want=0", bTmo); end
    total++; if (bBusy !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%0b want=0", bBusy); end
  endtask

  task automatic test_done_at_limit();
    expEntry_t e;
    logic [1:0] g, ak;
    logic [7:0] ds, da;
    logic tm;
    int lat;
    applyReset();
    // Spurious done while idle must not start anything.
    @(posedge clk); #1 txDone = 1'b1;
    @(posedge clk); #1 txDone = 1'b0;
    @(negedge clk);
    total++; if (bBusy !== 1'b0) begin bad++; $display("FAIL spurious_busy got=%0b want=0", bBusy); end
    total++; if (bAck !== 2'b00) begin bad++; $display("FAIL spurious_ack got=%0b want=0", bAck); end
    data = 16'h00C3;
    req = 2'b01;
    // Done lands on the edge where the counter equals TIMEOUT-1.
    expQ.push_back('{grant: 2'b01, data: 8'hC3, tmo: 1'b0, lat: TimeoutB + 1});
    xfer(1'b1, TimeoutB, 0, g, ds, ak, da, tm, lat);
    req = '0;
    e = expQ.pop_front();
    total++; if (ak !== e.grant) begin bad++; $display("FAIL limit_ack got=%0b want=%0b", ak, e.grant); end
    total++; if (tm !== e.tmo) begin bad++; $display("FAIL limit_tmo got=%0b want=%0b", tm, e.tmo); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL limit_lat got=%0d want=%0d", lat, e.lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    expEntry_t e;
    logic [1:0] g, ak;
    logic [7:0] ds, da;
    logic tm;
    int lat;
    int acks0;
    bit found;
    applyReset();
    data = 16'h6699;
    req = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (aSend === 1'b1) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_pre_send got=%0b want=1", found); end
    acks0 = ackA;
    repeat (3) @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    total++; if (aBusy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%0b want=0", aBusy); end
    total++; if (aGrant !== 2'b00) begin bad++; $display("FAIL rst_async_grant got=%0b want=0", aGrant); end
    total++; if (aData !== 8'h00) begin bad++; $display("FAIL rst_async_data got=%0h want=0", aData); end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    total++; if (ackA !== acks0) begin bad++; $display("FAIL rst_no_ack got=%0d want=%0d", ackA, acks0); end
    expQ.push_back('{grant: 2'b01, data: 8'h99, tmo: 1'b0, lat: 3});
    xfer(1'b0, 2, 0, g, ds, ak, da, tm, lat);
    req = '0;
    e = expQ.pop_front();
    total++; if (g !== e.grant) begin bad++; $display("FAIL rst_regrant got=%0b want=%0b", g, e.grant); end
    total++; if (ak !== e.grant) begin bad++; $display("FAIL rst_ack got=%0b want=%0b", ak, e.grant); end
    total++; if (ds !== e.data) begin bad++; $display("FAIL rst_data got=%0h want=%0h", ds, e.data); end
    @(negedge clk);
  endtask

  task automatic test_drop_mid_transfer();
    expEntry_t e;
    logic [1:0] g, ak;
    logic [7:0] ds, da;
    logic tm;
    int lat;
    int sends0;
    applyReset();
    data = 16'h7700;
    req = 2'b10;
    expQ.push_back('{grant: 2'b10, data: 8'h77, tmo: 1'b0, lat: 6});
    // Request drops and data is scrambled two cycles into the transfer.
    xfer(1'b0, 5, 2, g, ds, ak, da, tm, lat);
    e = expQ.pop_front();
    total++; if (g !== e.grant) begin bad++; $display("FAIL drop_grant got=%0b want=%0b", g, e.grant); end
    total++; if (ak !== e.grant) begin bad++; $display("FAIL drop_ack got=%0b want=%0b", ak, e.grant); end
    total++; if (da !== e.data) begin bad++; $display("FAIL drop_data_held got=%0h want=%0h", da, e.data); end
    total++; if (tm !== e.tmo) begin bad++; $display("FAIL drop_tmo got=%0b want=%0b", tm, e.tmo); end
    sends0 = sendA;
    repeat (5) @(negedge clk);
    total++; if (sendA !== sends0) begin bad++; $display("FAIL drop_no_regrant got=%0d want=%0d", sendA, sends0); end
    total++; if (aBusy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%0b want=0", aBusy); end
    data = 16'h4400;
    req = 2'b10;
    expQ.push_back('{grant: 2'b10, data: 8'h44, tmo: 1'b0, lat: 2});
    xfer(1'b0, 1, 0, g, ds, ak, da, tm, lat);
    req = '0;
    e = expQ.pop_front();
    total++; if (ak !== e.grant) begin bad++; $display("FAIL fresh_ack got=%0b want=%0b", ak, e.grant); end
    total++; if (da !== e.data) begin bad++; $display("FAIL fresh_data got=%0h want=%0h", da, e.data); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL fresh_lat got=%0d want=%0d", lat, e.lat); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_done_at_limit();
    test_reset_mid_wait();
    test_drop_mid_transfer();
    total++;
    if (expQ.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
